alu: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_comb.sv | 29 ++
 rtl/alu.sv | 34 +++
 tb/tb_alu.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: default datapath width and opcode encoding.
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 4;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_NOT = 3'b100,
        OP_XOR = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and operation mux; produces the next value of the result register.
module alu_comb
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        // Same-width arithmetic drops carry/borrow, giving modulo 2^WIDTH wrap.
        case (op_e'(op))
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = {a[WIDTH-2:0], 1'b0};
            OP_SHR:  y = {1'b0, a[WIDTH-1:1]};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 4-bit ALU: result reflects a/b/op sampled on the previous rising edge.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] result_d;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a  (a),
        .b  (b),
        .op (op),
        .y  (result_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
        end else begin
            result <= result_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, hand sequences, then randomized back-to-back traffic.
module tb_alu;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] result;

    int checks;
    int failures;

    typedef struct {
        logic         rst;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] exp;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    alu #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .op     (op),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed with integer arithmetic straight from the opcode table.
    function automatic logic [W-1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic [2:0] mop);
        int ia;
        int ib;
        int r;
        ia = int'(ma);
        ib = int'(mb);
        case (mop)
            3'd0:    r = (ia + ib) % MOD;
            3'd1:    r = (ia - ib + MOD) % MOD;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = (MOD - 1) - ia;
            3'd5:    r = ia ^ ib;
            3'd6:    r = (ia * 2) % MOD;
            default: r = ia / 2;
        endcase
        return W'(r);
    endfunction

    // Drive on the falling edge, check just after the next rising edge.
    task automatic step(input logic srst, input logic [W-1:0] sa, input logic [W-1:0] sb,
                        input logic [2:0] sop, input logic [W-1:0] exp, input string name);
        @(negedge clk);
        rst = srst;
        a   = sa;
        b   = sb;
        op  = sop;
        @(posedge clk);
        #1;
        checks++;
        if (result !== exp) begin
            failures++;
            $display("FAIL %s: rst=%b a=%b b=%b op=%b result=%b expected=%b",
                     name, srst, sa, sb, sop, result, exp);
        end
    endtask

    initial begin
        logic         rr;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [2:0]   rop;
        logic [W-1:0] rexp;

        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        a        = '0;
        b        = '0;
        op       = '0;

        vecs[0]  = '{1'b1, 4'b0111, 4'b1001, 3'b110, 4'b0000};
        vecs[1]  = '{1'b1, 4'b1111, 4'b1111, 3'b100, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0011, 4'b0101, 3'b000, 4'b1000};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0001, 3'b000, 4'b0000};
        vecs[4]  = '{1'b0, 4'b0110, 4'b0010, 3'b001, 4'b0100};
        vecs[5]  = '{1'b0, 4'b0001, 4'b0010, 3'b001, 4'b1111};
        vecs[6]  = '{1'b0, 4'b1111, 4'b1111, 3'b001, 4'b0000};
        vecs[7]  = '{1'b0, 4'b1100, 4'b1010, 3'b010, 4'b1000};
        vecs[8]  = '{1'b0, 4'b1100, 4'b1010, 3'b011, 4'b1110};
        vecs[9]  = '{1'b0, 4'b1100, 4'b1010, 3'b101, 4'b0110};
        vecs[10] = '{1'b0, 4'b0101, 4'b0000, 3'b100, 4'b1010};
        vecs[11] = '{1'b0, 4'b0000, 4'b1010, 3'b100, 4'b1111};
        vecs[12] = '{1'b0, 4'b1001, 4'b0110, 3'b110, 4'b0010};
        vecs[13] = '{1'b0, 4'b1001, 4'b0110, 3'b111, 4'b0100};
        vecs[14] = '{1'b0, 4'b0011, 4'b0101, 3'b000, 4'b1000};
        vecs[15] = '{1'b1, 4'b1111, 4'b0001, 3'b011, 4'b0000};
        vecs[16] = '{1'b0, 4'b1010, 4'b0110, 3'b000, 4'b0000};
        vecs[17] = '{1'b0, 4'b1001, 4'b0011, 3'b010, 4'b0001};
        vecs[18] = '{1'b0, 4'b1000, 4'b1000, 3'b111, 4'b0100};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp,
                 $sformatf("vec%0d", i));
        end

        // Held reset across several edges with changing nonzero ops.
        step(1'b1, 4'b1111, 4'b1111, 3'b011, 4'b0000, "hold_rst0");
        step(1'b1, 4'b1010, 4'b0101, 3'b100, 4'b0000, "hold_rst1");
        step(1'b1, 4'b0001, 4'b0001, 3'b000, 4'b0000, "hold_rst2");
        // First edge after release computes from current inputs, no residue.
        step(1'b0, 4'b0111, 4'b0001, 3'b001, 4'b0110, "post_rst");
        // Stable inputs keep producing the same value every edge.
        step(1'b0, 4'b0111, 4'b0001, 3'b001, 4'b0110, "stable0");
        step(1'b0, 4'b0111, 4'b0001, 3'b001, 4'b0110, "stable1");

        // Randomized back-to-back traffic with occasional reset pulses.
        for (int i = 0; i < 400; i++) begin
            rr   = ($urandom_range(0, 15) == 0);
            ra   = W'($urandom);
            rb   = W'($urandom);
            rop  = 3'($urandom);
            rexp = rr ? '0 : model(ra, rb, rop);
            step(rr, ra, rb, rop, rexp, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
